bi_cnt_seq_ctrl: RTL and testbench
==================================

Name: bi_cnt_seq_ctrl

Overview:
- Sequencer for the team's 8-bit bidirectional counter (bidirect_cnt8, ports en/load/up_down/d/q).
- Accepts a (start, target) command over a valid/ready handshake and loads the counter with start.
- Steps the counter toward target one count per clock, stops exactly on target, then pulses done.
- Supports pause and abort. Sits between a command source and the counter; the counter shares clk/reset.

Parameters:
- WIDTH, 8, counter/data width; must match the attached counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_start  input  WIDTH  value loaded into the counter
- cmd_target  input  WIDTH  value at which counting stops
- pause  input  1  hold count while high (RUN only)
- abort  input  1  cancel current command
- busy  output  1  command in progress (LOAD/RUN/DONE)
- done  output  1  one-cycle pulse: target reached
- dir_up  output  1  latched direction of current command
- cnt_en  output  1  to counter en
- cnt_load  output  1  to counter load
- cnt_up_down  output  1  to counter up_down (1 = up)
- cnt_d  output  WIDTH  to counter d
- cnt_q  input  WIDTH  from counter q

Behaviour:
- Reset: the interface is already decided as one clock, clk; reset is synchronous and active-high, named reset.
  - On a clk edge with reset=1: state=IDLE; cmd_ready=1 after release; busy=0, done=0, dir_up=0, cnt_en=0, cnt_load=0, cnt_up_down=0, cnt_d=0.
  - Latched start/target are cleared to 0.
- Counter contract, per edge:
  - en=0: hold.
  - en=1, load=1: q<=d.
  - en=1, load=0: q<=q+1 if up_down else q-1, modulo 2^WIDTH.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1; all cnt_* = 0.
  - On cmd_valid&&cmd_ready: latch start and target; dir_up = (target >= start), unsigned; go to LOAD.
- LOAD (exactly 1 cycle): cnt_en=1, cnt_load=1, cnt_d=start, cnt_up_down=dir_up; go to RUN.
- RUN:
  - cnt_up_down=dir_up, cnt_load=0.
  - If cnt_q==target: cnt_en=0, go to DONE (combinational compare on cnt_q).
  - Else if pause: cnt_en=0, stay in RUN.
  - Else: cnt_en=1, stay in RUN.
- DONE (1 cycle): done=1, cnt_en=0; go to IDLE.
- Latency: with no pause, done is high in the cycle starting |target-start|+3 edges after the accept edge. Each paused RUN cycle adds 1.
- cmd_ready is 0 in LOAD/RUN/DONE. A command offered during DONE is accepted at the earliest in the following IDLE cycle.
- abort: in LOAD or RUN it forces cnt_en=0 in that cycle and goes to IDLE with no done pulse. The counter keeps its last value. Ignored in IDLE and DONE.
- Priority: reset > abort > target-match > pause.
- start==target: LOAD, then one RUN cycle with no step, then DONE (3 cycles).
- Without the feature, no wrap-around: direction always moves monotonically toward target.

Optional Feature:
- Macro: BI_CNT_SHORTEST_EN.
- Defined: direction is chosen by the shortest modular path.
  - dir_up = ((target-start) mod 2^WIDTH) <= 2^(WIDTH-1); ties go up.
  - Counting may wrap through 0/2^WIDTH-1.
  - Latency = min(up distance, down distance)+3.
- Undefined: direction rule as in Behaviour, never wraps.

Decomposition:
- Package bi_cnt_pkg:
  - state enum {IDLE, LOAD, RUN, DONE}.
  - CNT_W=8 default constant.
  - Pure function for direction select, covering both macro variants.
- Single flat module; no sub-module needed. The counter is instantiated alongside the controller by the integrating level or the bench.

Test Plan:
- start=10, target=14, accept at edge N: LOAD cycle N+1 (cnt_d=10); q = 10,11,12,13,14 at edges N+2..N+6; done=1 in cycle N+7 only; cnt_en=0 thereafter.
- start=200, target=195: dir_up=0; q counts down 200 to 195; done at accept+8; no underflow.
- start=target=77: q=77 after load; no step; done at accept+3.
- start=10, target=14, pause high for 3 RUN cycles after q=12: q holds 12; done at accept+10.
- Abort when q=12 (start=10, target=20): returns to IDLE next cycle, cmd_ready=1, no done, q stays 12. A new command is then accepted normally.
- BI_CNT_SHORTEST_EN defined, start=250, target=3: dir_up=1; q goes 250…255,0…3; done at accept+12. Without the macro: dir_up=0, done at accept+250.

Source files
------------

// File: rtl/bi_cnt_pkg.sv
// Shared types and helpers for the bidirectional counter sequencer.
// BI_CNT_SHORTEST_EN selects shortest-modular-path direction in dir_select.
package bi_cnt_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Direction for a (start, target) pair; values are zero-extended, width <= 32.
   function automatic logic dir_select(input logic [31:0] start,
                                       input logic [31:0] target,
                                       input int unsigned width);
      logic [31:0] mask;
      logic [31:0] diff;
      logic [31:0] half;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      diff = (target - start) & mask;
      half = 32'd1 << (width - 1);
`ifdef BI_CNT_SHORTEST_EN
      // Ties (exactly half-way round) go up.
      return (diff <= half);
`else
      if (diff == half) begin
         return ((target & mask) >= (start & mask));
      end
      return ((target & mask) >= (start & mask));
`endif
   endfunction

endpackage

// File: rtl/bi_cnt_seq_ctrl.sv
// Sequencer that loads the attached bidirectional counter and steps it to a target.
// Build option BI_CNT_SHORTEST_EN: pick direction by shortest modular path (may wrap).
module bi_cnt_seq_ctrl
   import bi_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   // cmd handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE and does not depend on cmd_valid.
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             dir_up,
   output logic             cnt_en,
   output logic             cnt_load,
   output logic             cnt_up_down,
   output logic [WIDTH-1:0] cnt_d,
   input  logic [WIDTH-1:0] cnt_q
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             dir_q, dir_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         start_q  <= '0;
         target_q <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         target_q <= target_d;
         dir_q    <= dir_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      target_d    = target_q;
      dir_d       = dir_q;
      cmd_ready   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      cnt_en      = 1'b0;
      cnt_load    = 1'b0;
      cnt_up_down = 1'b0;
      cnt_d       = '0;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               start_d  = cmd_start;
               target_d = cmd_target;
               dir_d    = dir_select(32'(cmd_start), 32'(cmd_target), WIDTH);
               state_d  = LOAD;
            end
         end
         LOAD: begin
            busy        = 1'b1;
            cnt_up_down = dir_q;
            if (abort) begin
               state_d = IDLE;
            end else begin
               cnt_en   = 1'b1;
               cnt_load = 1'b1;
               cnt_d    = start_q;
               state_d  = RUN;
            end
         end
         RUN: begin
            busy        = 1'b1;
            cnt_up_down = dir_q;
            // Abort beats target match, which beats pause.
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == target_q) begin
               state_d = DONE;
            end else if (!pause) begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dir_up = dir_q;

endmodule

// File: tb/tb_bi_cnt_seq_ctrl.sv
// Directed bench for bi_cnt_seq_ctrl with a behavioural bidirect_cnt8 attached.
module tb_bi_cnt_seq_ctrl;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_target;
  logic         pause;
  logic         abort;
  logic         busy;
  logic         done;
  logic         dir_up;
  logic         cnt_en;
  logic         cnt_load;
  logic         cnt_up_down;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_dir_q[$];
  int           exp_lat_q[$];
  logic [W-1:0] exp_ld_q[$];

  bi_cnt_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target),
    .pause(pause), .abort(abort),
    .busy(busy), .done(done), .dir_up(dir_up),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up_down(cnt_up_down),
    .cnt_d(cnt_d), .cnt_q(cnt_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // attached counter model
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (cnt_en) begin
      if (cnt_load) cnt_q <= cnt_d;
      else if (cnt_up_down) cnt_q <= cnt_q + 8'd1;
      else cnt_q <= cnt_q - 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] t,
                      input bit expect_done, input int lat, input logic dir);
    bit got;
    got = 0;
    @(posedge clk); #2;
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_target = t;
    exp_ld_q.push_back(s);
    if (expect_done) begin
      exp_q.push_back(t);
      exp_dir_q.push_back(dir);
      exp_lat_q.push_back(lat);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_q_value(input logic [W-1:0] v);
    bit got;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (cnt_q == v && busy) begin
        got = 1;
        break;
      end
    end
    if (!got) check("wait_q_timeout", 0, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (cnt_load) begin
        if (exp_ld_q.size() == 0) check("unexpected_load", 1, 0);
        else begin
          check("load_d", cnt_d, exp_ld_q.pop_front());
          check("load_en", cnt_en, 1);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", 1, 0);
        else begin
          check("done_latency", cyc - acc_cyc, exp_lat_q.pop_front());
          check("done_q", cnt_q, exp_q.pop_front());
          check("done_dir", dir_up, exp_dir_q.pop_front());
          check("done_en_low", cnt_en, 0);
        end
      end
    end
  end

  // stimulus
  initial begin
    bit drained;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_target = '0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", dir_up, 0);
    check("rst_en", cnt_en, 0);
    check("rst_load", cnt_load, 0);
    check("rst_updown", cnt_up_down, 0);
    check("rst_d", cnt_d, 0);

    send(8'd10, 8'd14, 1, 7, 1'b1);
    send(8'd200, 8'd195, 1, 8, 1'b0);
    send(8'd77, 8'd77, 1, 3, 1'b1);

    // pause for three RUN cycles while q sits at 12
    send(8'd10, 8'd14, 1, 10, 1'b1);
    wait_q_value(8'd12);
    pause = 1'b1;
    repeat (3) @(posedge clk);
    #2 pause = 1'b0;
    check("pause_hold", cnt_q, 12);

    // abort mid-run: no done, counter keeps its value
    send(8'd10, 8'd20, 0, 0, 1'b1);
    wait_q_value(8'd12);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_q", cnt_q, 12);
    @(posedge clk); #2;
    check("abort_q_hold", cnt_q, 12);

    send(8'd5, 8'd3, 1, 5, 1'b0);
`ifdef BI_CNT_SHORTEST_EN
    send(8'd250, 8'd3, 1, 12, 1'b1);
`else
    send(8'd250, 8'd3, 1, 250, 1'b0);
`endif

    drained = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        drained = 1;
        break;
      end
    end
    if (!drained) check("drain_timeout", 0, 1);
    check("final_ready", cmd_ready, 1);
    check("final_ld_q_empty", exp_ld_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
